// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces one raw button, emitting a
// clean level, press/release strobes and a one-shot long-press indication.
module button_conditioner #(
  parameter int SYNC_STAGES       = 3,
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_hold
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_PRESS_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0] db_cnt, db_cnt_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic s, press_d, release_d, long_d, hold_d;
  assign s = sync[SYNC_STAGES-1];
  always_comb begin
    state_d    = state;
    db_cnt_d   = db_cnt;
    hold_cnt_d = hold_cnt;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    hold_d     = o_hold;
    case (state)
      IDLE: if (s) begin
        state_d  = ARM;
        db_cnt_d = '0;
      end
      ARM:
        if (!s) state_d = IDLE;
        else if (db_cnt == D_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else db_cnt_d = db_cnt + 1'b1;
      HELD:
        if (!s) begin
          state_d  = DISARM;
          db_cnt_d = '0;
        end else if (hold_cnt != L_LAST) hold_cnt_d = hold_cnt + 1'b1;
        else if (!o_hold) begin
          long_d = 1'b1;
          hold_d = 1'b1;
        end
      DISARM:
        if (s) state_d = HELD;
        else if (db_cnt == D_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          hold_d    = 1'b0;
        end else db_cnt_d = db_cnt + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync         <= '0;
      state        <= IDLE;
      db_cnt       <= '0;
      hold_cnt     <= '0;
      o_level      <= 1'b0;
      o_press      <= 1'b0;
      o_release    <= 1'b0;
      o_long_press <= 1'b0;
      o_hold       <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], i_btn};
      state        <= state_d;
      db_cnt       <= db_cnt_d;
      hold_cnt     <= hold_cnt_d;
      o_level      <= state_d == HELD || state_d == DISARM;
      o_press      <= press_d;
      o_release    <= release_d;
      o_long_press <= long_d;
      o_hold       <= hold_d;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random button runs checked
// against a run-length model of the debounce and long-press rules.
module tb_button_conditioner;
  localparam int S = 3, D = 4, L = 10;
  logic clk = 1'b0, reset = 1'b1, i_btn = 1'b0;
  logic o_level, o_press, o_release, o_long_press, o_hold;
  int n_tests = 0, n_fail = 0;
  logic [S-1:0] m_sync = '0;
  logic m_level = 0, m_press = 0, m_rel = 0, m_long = 0, m_hold = 0;
  int run = 0, prog = 0;
  button_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_long_press(o_long_press), .o_hold(o_hold)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0b exp=%0b at %0t", tag, got, exp, $time);
    end
  endtask
  // Level flips once the synchronized input has disagreed with it for D+1
  // consecutive edges; a hold advances only on edges of undisturbed agreement.
  task automatic model(input logic b, input logic r);
    logic sv;
    m_press = 0; m_rel = 0; m_long = 0;
    if (r) begin
      m_sync = '0; m_level = 0; m_hold = 0; run = 0; prog = 0;
      return;
    end
    sv = m_sync[S-1];
    m_sync = {m_sync[S-2:0], b};
    if (sv != m_level) begin
      run++;
      if (run == D + 1) begin
        run = 0;
        if (!m_level) begin m_level = 1; m_press = 1; prog = 0; end
        else begin m_level = 0; m_rel = 1; m_hold = 0; end
      end
    end else if (run != 0) run = 0;
    else if (m_level && !m_hold) begin
      prog++;
      if (prog == L) begin m_long = 1; m_hold = 1; end
    end
  endtask
  task automatic step(input logic b, input logic r);
    i_btn = b;
    reset = r;
    @(posedge clk);
    model(b, r);
    #1;
    chk("level", o_level, m_level);
    chk("press", o_press, m_press);
    chk("release", o_release, m_rel);
    chk("long_press", o_long_press, m_long);
    chk("hold", o_hold, m_hold);
    chk("press_xor_release", o_press & o_release, 1'b0);
    chk("long_xor_press", o_long_press & o_press, 1'b0);
  endtask
  task automatic hold_for(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask
  initial begin
    logic b;
    int len;
    step(0, 1); step(0, 1);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0);
      chk("t1_press_at_8", o_press, 1'(i == 8));
      chk("t1_level", o_level, 1'(i >= 8));
    end
    hold_for(1, 20);
    chk("t3_hold_set", o_hold, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0);
      chk("t3_release_at_8", o_release, 1'(i == 8));
    end
    chk("t3_hold_clear", o_hold, 1'b0);
    step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    hold_for(1, 12);
    hold_for(0, 2);
    hold_for(1, 25);
    hold_for(0, 12);
    hold_for(1, 6);
    step(1, 1);
    chk("t5_arm_reset_level", o_level, 1'b0);
    hold_for(0, 6);
    hold_for(1, 25);
    step(1, 1);
    chk("t5_held_reset_hold", o_hold, 1'b0);
    step(1, 1);
    for (int i = 1; i <= 10; i++) begin
      step(1, 0);
      chk("t6_press_at_8", o_press, 1'(i == 8));
    end
    hold_for(0, 12);
    b = 1'b0;
    repeat (150) begin
      b = ~b;
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 3);
        1: len = $urandom_range(4, 8);
        default: len = $urandom_range(9, 40);
      endcase
      if ($urandom_range(0, 30) == 0) step(b, 1'b1);
      hold_for(b, len);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
